branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised dynamic branch predictor for the 5-stage pipelined core. It replaces the static always-taken IF-stage prediction with a table of saturating counters and a direct-mapped branch target buffer (BTB). The IF stage looks up by PC in the same cycle. The EX stage reports each resolved conditional branch back through an update port, which trains the tables and counts mispredictions.

## Interface
- `XLEN`, 64: PC and target width.
- `BHT_ENTRIES`, 64: number of counters. Must be a power of 2. `IDX_W = $clog2(BHT_ENTRIES)`.
- `CTR_BITS`, 2: width of each saturating counter, at least 1.
- `BTB_ENTRIES`, 16: number of BTB entries. Must be a power of 2. `BTB_IDX_W = $clog2(BTB_ENTRIES)`.
- `GHR_BITS`, 6: global history length, at most `IDX_W`. Used only when `BP_GSHARE_EN` is defined.
- `clk` in 1: the single clock. All state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `lookup_pc` in XLEN: PC of the instruction being fetched.
- `pred_taken` out 1: taken/not-taken prediction.
- `pred_btb_hit` out 1: the BTB holds a target for `lookup_pc`.
- `pred_target` out XLEN: BTB target when hit, else 0.
- `pred_index` out IDX_W: counter index used for this lookup. The pipeline carries it to EX.
- `update_valid` in 1: a conditional branch resolved in EX this cycle.
- `update_pc` in XLEN: PC of the resolved branch.
- `update_index` in IDX_W: the `pred_index` that was captured at fetch.
- `update_taken` in 1: actual outcome.
- `update_target` in XLEN: actual taken target.
- `update_mispredict` in 1: the pipeline flushed for this branch.
- `stat_branches` out 32: number of updates since reset.
- `stat_mispredicts` out 32: number of mispredictions since reset.

## Operation
- **Counter index without the macro:** `pc[IDX_W+1:2]`.
- **Counter index with the macro:** see Configuration.
- **Prediction:** `pred_taken` is the MSB of the counter at `pred_index`.
- **BTB lookup:**
  - BTB index is `pc[BTB_IDX_W+1:2]`.
  - Tag is `pc[XLEN-1:BTB_IDX_W+2]`.
  - Hit means the entry is valid and its tag matches.
- **Counter training:** when `update_valid` is high, the counter at `update_index`:
  - increments if `update_taken` is 1, saturating at `2^CTR_BITS-1`;
  - decrements if `update_taken` is 0, saturating at 0.
- **BTB training:**
  - When `update_valid` and `update_taken` are both high, the entry for `update_pc` is written: valid=1, tag, and `update_target`. Any previous occupant is overwritten.
  - Not-taken updates leave the BTB unchanged.
- **Statistics:** on `update_valid`, `stat_branches` increments. If `update_mispredict` is also high, `stat_mispredicts` increments. Both saturate at `32'hFFFF_FFFF` and do not wrap.
- **Update without `update_valid`:** all other update inputs are ignored.

## Timing
- **Lookup is combinational.** Outputs are valid in the same cycle as `lookup_pc`, because instruction memory is also combinational.
- **Update has 1-cycle latency.** The write happens at the edge ending the `update_valid` cycle. A lookup of the same index or entry in that same cycle sees the old value; there is no bypass.
- **Reset state:** while `reset` is sampled high, at the edge:
  - every counter is set to `2^(CTR_BITS-1)-1` (weakly not-taken, 01 for 2 bits);
  - all BTB valid bits are cleared;
  - GHR is 0;
  - both stat counters are 0.
- **Outputs after reset:** `pred_taken`=0, `pred_btb_hit`=0, `pred_target`=0. `pred_index` is `lookup_pc[IDX_W+1:2]`.
- **Reset vs. update:** reset has priority over an update in the same cycle, so that update is lost.
- **Reset mid-operation:** stale `update_index` values still in flight after reset are legal and simply train the reset table.
- **No stall input:** the pipeline holds `lookup_pc` stable during a stall and must not raise `update_valid` for a flushed or bubbled branch.

## Configuration
- **`BP_GSHARE_EN` defined:**
  - A `GHR_BITS` global history register shifts left and inserts `update_taken` on each `update_valid`. History is non-speculative, updated at resolve.
  - Counter index is `pc[IDX_W+1:2] XOR {{(IDX_W-GHR_BITS){1'b0}}, ghr}`.
  - `update_index` makes training use the history that was seen at fetch.
- **`BP_GSHARE_EN` undefined:** no GHR flops, and the index is the PC bits alone.

## Structure
- **Shared package `bp_pkg`:**
  - counter reset constant;
  - counter saturation helper functions `ctr_inc` / `ctr_dec`;
  - BTB entry struct `{valid, tag, target}`.
- **Sub-module:** `branch_target_buffer` holds the BTB storage, tag compare and write port. The counter table, GHR and statistics stay in `branch_predictor`.

## Test plan
- **Reset:** after reset, lookup PC 0x100 -> `pred_taken`=0, `pred_btb_hit`=0, `pred_target`=0, stats 0.
- **Training:** two taken updates for PC 0x100 with target 0x80 -> next lookup of 0x100 gives `pred_taken`=1, hit=1, target=0x80. Counter for 0x100 = 3.
- **Saturation:** five not-taken updates on one index -> counter = 0, `pred_taken`=0. BTB entry still valid, target unchanged.
- **Aliasing:** with `BTB_ENTRIES`=16, a taken update for 0x100, then one for 0x140 (same BTB index, different tag) -> lookup of 0x100 misses, lookup of 0x140 hits.
- **Same-cycle lookup and update:** lookup and update of the same index in one cycle -> lookup returns the old prediction, and the new one appears next cycle. Reset asserted together with `update_valid` -> the table stays at its reset value.
- **Statistics:** 10 updates, 3 of them with `update_mispredict` -> `stat_branches`=10, `stat_mispredicts`=3.
- **Gshare:** with `BP_GSHARE_EN` defined, branch at 0x200 alternating T/N trained 20 times -> the last 8 predictions are all correct.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// ============================================================================
// Module      : bp_pkg
// Description : Shared types and helpers for the dynamic branch predictor.
//               Saturating-counter helpers, counter reset value and the
//               BTB entry record.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bp_pkg;

    // Widest counter and address supported by the shared helpers/record.
    localparam int c_CTR_MAX_W = 16;
    localparam int c_XLEN_MAX  = 64;

    // BTB entry record. Tag and target are stored in the widest field and
    // the BTB uses only the low bits it needs.
    typedef struct packed {
        logic                  valid;
        logic [c_XLEN_MAX-1:0] tag;
        logic [c_XLEN_MAX-1:0] target;
    } btb_entry_t;

    // Largest value of a bits-wide counter.
    function automatic logic [c_CTR_MAX_W-1:0] ctr_max(input int unsigned bits);
        return c_CTR_MAX_W'((32'd1 << bits) - 32'd1);
    endfunction

    // Reset value: weakly not-taken (just below the taken threshold).
    function automatic logic [c_CTR_MAX_W-1:0] ctr_reset(input int unsigned bits);
        return c_CTR_MAX_W'((32'd1 << (bits - 32'd1)) - 32'd1);
    endfunction

    // Increment, saturating at the counter maximum.
    function automatic logic [c_CTR_MAX_W-1:0] ctr_inc(input logic [c_CTR_MAX_W-1:0] ctr,
                                                       input int unsigned bits);
        return (ctr >= ctr_max(bits)) ? ctr : ctr + 1'b1;
    endfunction

    // Decrement, saturating at zero.
    function automatic logic [c_CTR_MAX_W-1:0] ctr_dec(input logic [c_CTR_MAX_W-1:0] ctr);
        return (ctr == '0) ? ctr : ctr - 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_predictor_btb.sv
// ============================================================================
// Module      : branch_target_buffer
// Description : Direct-mapped branch target buffer. Combinational tag-compare
//               lookup, single write port that overwrites the indexed entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_target_buffer
    import bp_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int BTB_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] i_lookup_pc,
    output logic            o_hit,
    output logic [XLEN-1:0] o_target,
    input  logic            i_wr_en,
    input  logic [XLEN-1:0] i_wr_pc,
    input  logic [XLEN-1:0] i_wr_target
);

    localparam int c_IDX_W = $clog2(BTB_ENTRIES);
    localparam int c_TAG_W = XLEN - c_IDX_W - 2;

    btb_entry_t r_entries [BTB_ENTRIES];

    logic [c_IDX_W-1:0] w_lk_idx;
    logic [c_TAG_W-1:0] w_lk_tag;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic [c_TAG_W-1:0] w_wr_tag;
    btb_entry_t         w_rd_entry;
    logic               w_unused;

    assign w_lk_idx   = i_lookup_pc[c_IDX_W+1:2];
    assign w_lk_tag   = i_lookup_pc[XLEN-1:c_IDX_W+2];
    assign w_wr_idx   = i_wr_pc[c_IDX_W+1:2];
    assign w_wr_tag   = i_wr_pc[XLEN-1:c_IDX_W+2];
    assign w_rd_entry = r_entries[w_lk_idx];

    // Lookup: hit when the indexed entry is valid and the tag matches.
    always_comb begin
        o_hit    = w_rd_entry.valid && (w_rd_entry.tag[c_TAG_W-1:0] == w_lk_tag);
        o_target = o_hit ? w_rd_entry.target[XLEN-1:0] : '0;
    end

    // Storage: reset clears valid bits only; a write replaces the whole entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_entries[i].valid <= 1'b0;
            end
        end else if (i_wr_en) begin
            r_entries[w_wr_idx] <= '{valid:  1'b1,
                                     tag:    c_XLEN_MAX'(w_wr_tag),
                                     target: c_XLEN_MAX'(i_wr_target)};
        end
    end

    // Byte-offset bits and the unused high field bits are intentionally dropped.
    assign w_unused = ^{w_rd_entry, i_lookup_pc[1:0], i_wr_pc[1:0]};

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
// Module      : branch_predictor
// Description : Dynamic branch predictor: table of saturating counters plus a
//               direct-mapped BTB, combinational lookup, trained by resolved
//               branches from EX, with branch/mispredict statistics.
//               Define BP_GSHARE_EN to XOR a global history register into the
//               counter index (gshare).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor
    import bp_pkg::*;
#(
    parameter  int XLEN        = 64,
    parameter  int BHT_ENTRIES = 64,
    parameter  int CTR_BITS    = 2,
    parameter  int BTB_ENTRIES = 16,
    parameter  int GHR_BITS    = 6,
    localparam int IDX_W       = $clog2(BHT_ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  lookup_pc,
    output logic             pred_taken,
    output logic             pred_btb_hit,
    output logic [XLEN-1:0]  pred_target,
    output logic [IDX_W-1:0] pred_index,
    input  logic             update_valid,
    input  logic [XLEN-1:0]  update_pc,
    input  logic [IDX_W-1:0] update_index,
    input  logic             update_taken,
    input  logic [XLEN-1:0]  update_target,
    input  logic             update_mispredict,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_mispredicts
);

    logic [CTR_BITS-1:0] r_bht [BHT_ENTRIES];
    logic [31:0]         r_stat_br;
    logic [31:0]         r_stat_mp;

    logic [IDX_W-1:0]    w_lookup_idx;
    logic [CTR_BITS-1:0] w_lookup_ctr;
    logic [CTR_BITS-1:0] w_ctr_next;
    logic                w_unused;

`ifdef BP_GSHARE_EN
    logic [GHR_BITS-1:0] r_ghr;

    // Non-speculative global history: shift in each resolved outcome.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ghr <= '0;
        end else if (update_valid) begin
            r_ghr <= GHR_BITS'({r_ghr, update_taken});
        end
    end

    assign w_lookup_idx = lookup_pc[IDX_W+1:2] ^ IDX_W'(r_ghr);
`else
    logic [GHR_BITS-1:0] w_ghr_unused;

    assign w_ghr_unused = '0;
    assign w_lookup_idx = lookup_pc[IDX_W+1:2];
`endif

    assign w_lookup_ctr = r_bht[w_lookup_idx];
    assign pred_index   = w_lookup_idx;
    assign pred_taken   = w_lookup_ctr[CTR_BITS-1];

    // Next value of the trained counter; index comes from fetch time.
    always_comb begin
        w_ctr_next = r_bht[update_index];
        if (update_taken) begin
            w_ctr_next = CTR_BITS'(ctr_inc(c_CTR_MAX_W'(r_bht[update_index]), CTR_BITS));
        end else begin
            w_ctr_next = CTR_BITS'(ctr_dec(c_CTR_MAX_W'(r_bht[update_index])));
        end
    end

    // Counter table: reset to weakly not-taken, reset wins over an update.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= CTR_BITS'(ctr_reset(CTR_BITS));
            end
        end else if (update_valid) begin
            r_bht[update_index] <= w_ctr_next;
        end
    end

    // Saturating branch and mispredict counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_br <= '0;
            r_stat_mp <= '0;
        end else if (update_valid) begin
            if (r_stat_br != 32'hFFFF_FFFF) begin
                r_stat_br <= r_stat_br + 32'd1;
            end
            if (update_mispredict && (r_stat_mp != 32'hFFFF_FFFF)) begin
                r_stat_mp <= r_stat_mp + 32'd1;
            end
        end
    end

    assign stat_branches    = r_stat_br;
    assign stat_mispredicts = r_stat_mp;

    // Only taken branches install or refresh a BTB target.
    branch_target_buffer #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk         (clk),
        .rst         (reset),
        .i_lookup_pc (lookup_pc),
        .o_hit       (pred_btb_hit),
        .o_target    (pred_target),
        .i_wr_en     (update_valid && update_taken),
        .i_wr_pc     (update_pc),
        .i_wr_target (update_target)
    );

    // PC bits outside the counter index do not take part in prediction.
    assign w_unused = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// Module      : tb_branch_predictor
// Description : Directed self-checking bench for branch_predictor (default
//               parameters). The gshare scenario runs when BP_GSHARE_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] lookup_pc;
    logic        pred_taken;
    logic        pred_btb_hit;
    logic [63:0] pred_target;
    logic [5:0]  pred_index;
    logic        update_valid;
    logic [63:0] update_pc;
    logic [5:0]  update_index;
    logic        update_taken;
    logic [63:0] update_target;
    logic        update_mispredict;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int checks   = 0;
    int failures = 0;

    branch_predictor dut (
        .clk               (clk),
        .reset             (reset),
        .lookup_pc         (lookup_pc),
        .pred_taken        (pred_taken),
        .pred_btb_hit      (pred_btb_hit),
        .pred_target       (pred_target),
        .pred_index        (pred_index),
        .update_valid      (update_valid),
        .update_pc         (update_pc),
        .update_index      (update_index),
        .update_taken      (update_taken),
        .update_target     (update_target),
        .update_mispredict (update_mispredict),
        .stat_branches     (stat_branches),
        .stat_mispredicts  (stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_update(input logic v, input logic [63:0] pc, input logic [5:0] idx,
                              input logic t, input logic [63:0] tgt, input logic mp);
        update_valid      = v;
        update_pc         = pc;
        update_index      = idx;
        update_taken      = t;
        update_target     = tgt;
        update_mispredict = mp;
    endtask

    initial begin
        reset     = 1'b1;
        lookup_pc = 64'h100;
        set_update(1'b0, 64'h0, 6'd0, 1'b0, 64'h0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        #1;

        // Reset state
        check("rst_taken",  {63'd0, pred_taken},   64'd0);
        check("rst_hit",    {63'd0, pred_btb_hit}, 64'd0);
        check("rst_target", pred_target,           64'd0);
        check("rst_index",  {58'd0, pred_index},   64'd0);
        check("rst_br",     {32'd0, stat_branches},    64'd0);
        check("rst_mp",     {32'd0, stat_mispredicts}, 64'd0);

        // First taken update; same-cycle lookup still sees the old state
        set_update(1'b1, 64'h100, 6'd0, 1'b1, 64'h80, 1'b1);
        #1;
        check("same_cyc_taken", {63'd0, pred_taken},   64'd0);
        check("same_cyc_hit",   {63'd0, pred_btb_hit}, 64'd0);
        tick();
        update_mispredict = 1'b0;
        #1;
        check("next_cyc_taken",  {63'd0, pred_taken},   64'd1);
        check("next_cyc_hit",    {63'd0, pred_btb_hit}, 64'd1);
        check("next_cyc_target", pred_target,           64'h80);
        tick();
        update_valid = 1'b0;
        #1;
        check("train2_taken", {63'd0, pred_taken}, 64'd1);
        check("train2_br",    {32'd0, stat_branches},    64'd2);
        check("train2_mp",    {32'd0, stat_mispredicts}, 64'd1);

        // Five not-taken updates: 3 -> 2 -> 1 -> 0 -> 0 -> 0
        set_update(1'b1, 64'h100, 6'd0, 1'b0, 64'hDEAD, 1'b0);
        tick();
        update_valid = 1'b0;
        #1;
        check("ctr_was_3", {63'd0, pred_taken}, 64'd1);
        update_valid = 1'b1;
        tick();
        tick();
        tick();
        tick();
        update_valid = 1'b0;
        #1;
        check("sat0_taken",  {63'd0, pred_taken},   64'd0);
        check("sat0_hit",    {63'd0, pred_btb_hit}, 64'd1);
        check("sat0_target", pred_target,           64'h80);
        // One taken step from a floored counter gives 1, still not-taken
        set_update(1'b1, 64'h100, 6'd0, 1'b1, 64'h80, 1'b0);
        tick();
        update_valid = 1'b0;
        #1;
        check("sat0_floor", {63'd0, pred_taken},    64'd0);
        check("sat_br",     {32'd0, stat_branches}, 64'd8);

        // Aliasing: 0x140 shares BTB slot 0 with 0x100
        set_update(1'b1, 64'h140, 6'd16, 1'b1, 64'h400, 1'b0);
        tick();
        update_valid = 1'b0;
        #1;
        check("alias_old_hit",    {63'd0, pred_btb_hit}, 64'd0);
        check("alias_old_target", pred_target,           64'd0);
        lookup_pc = 64'h140;
        #1;
        check("alias_new_hit",    {63'd0, pred_btb_hit}, 64'd1);
        check("alias_new_target", pred_target,           64'h400);
        check("alias_new_taken",  {63'd0, pred_taken},   64'd1);
        check("alias_new_index",  {58'd0, pred_index},   64'd16);

        // Update inputs without update_valid are ignored
        set_update(1'b0, 64'h140, 6'd16, 1'b1, 64'h999, 1'b1);
        tick();
        check("novalid_target", pred_target,              64'h400);
        check("novalid_br",     {32'd0, stat_branches},    64'd9);
        check("novalid_mp",     {32'd0, stat_mispredicts}, 64'd1);

        // Reset together with an update: the update is lost
        reset     = 1'b1;
        lookup_pc = 64'h100;
        set_update(1'b1, 64'h100, 6'd0, 1'b1, 64'h80, 1'b1);
        tick();
        reset        = 1'b0;
        update_valid = 1'b0;
        #1;
        check("rstupd_taken", {63'd0, pred_taken},   64'd0);
        check("rstupd_hit",   {63'd0, pred_btb_hit}, 64'd0);
        check("rstupd_br",    {32'd0, stat_branches},    64'd0);
        check("rstupd_mp",    {32'd0, stat_mispredicts}, 64'd0);
        // Reset value is weakly not-taken: one taken update flips it
        set_update(1'b1, 64'h100, 6'd0, 1'b1, 64'h80, 1'b0);
        tick();
        update_valid = 1'b0;
        #1;
        check("rst_weak_taken", {63'd0, pred_taken}, 64'd1);

        // Statistics: 10 updates, 3 mispredicts
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            set_update(1'b1, 64'h1000 + 64'(4 * i), 6'(i), 1'b0, 64'h0,
                       (i == 2) || (i == 5) || (i == 8));
            tick();
        end
        set_update(1'b0, 64'h1000, 6'd0, 1'b0, 64'h0, 1'b1);
        tick();
        check("stat_br", {32'd0, stat_branches},    64'd10);
        check("stat_mp", {32'd0, stat_mispredicts}, 64'd3);

`ifdef BP_GSHARE_EN
        // Gshare: alternating T/N at 0x200 becomes fully predictable
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        lookup_pc = 64'h200;
        for (int i = 0; i < 20; i++) begin
            logic       outcome;
            logic [5:0] idx;
            logic       pred;
            outcome = (i % 2) == 0;
            #1;
            idx  = pred_index;
            pred = pred_taken;
            if (i >= 12) begin
                check($sformatf("gshare_pred_%0d", i), {63'd0, pred}, {63'd0, outcome});
            end
            set_update(1'b1, 64'h200, idx, outcome, 64'h300, pred != outcome);
            tick();
            update_valid = 1'b0;
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
